// File: rtl/window_builder.sv
// rtl/window_builder.sv - streaming 3x3 RGB window generator with two line buffers
module window_builder #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [23:0]  pix_in,
    input  logic         pix_valid,
    input  logic         sof,
    output logic [215:0] w,
    output logic         load,
    output logic         frame_done
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    logic [CW-1:0] col, cur_col, next_col;
    logic [RW-1:0] row, cur_row, next_row;
    logic [23:0]   lb1 [IMG_W];
    logic [23:0]   lb2 [IMG_W];
    logic [23:0]   lb1_rd, lb2_rd;
    logic [23:0]   a, b, c, d, e, f, g, h, i;
    logic          emit, last;

    // sof relabels the incoming pixel as (0,0) regardless of counter state
    always_comb begin
        cur_col  = sof ? '0 : col;
        cur_row  = sof ? '0 : row;
        next_col = cur_col + CW'(1);
        next_row = cur_row;
        if (cur_col == CW'(IMG_W - 1)) begin
            next_col = '0;
            next_row = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + RW'(1);
        end
    end

    assign lb1_rd = lb1[cur_col];
    assign lb2_rd = lb2[cur_col];
    assign emit   = pix_valid && !sof && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    assign last   = (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));

    // Line buffers are never cleared; row gating keeps stale entries out of windows
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            lb2[cur_col] <= lb1_rd;
            lb1[cur_col] <= pix_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col        <= '0;
            row        <= '0;
            a <= '0; b <= '0; c <= '0;
            d <= '0; e <= '0; f <= '0;
            g <= '0; h <= '0; i <= '0;
            w          <= '0;
            load       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            load       <= 1'b0;
            frame_done <= 1'b0;
            if (pix_valid) begin
                col <= next_col;
                row <= next_row;
                a <= b; b <= c; c <= lb2_rd;
                d <= e; e <= f; f <= lb1_rd;
                g <= h; h <= i; i <= pix_in;
                if (emit) begin
                    w          <= {b, c, lb2_rd, e, f, lb1_rd, h, i, pix_in};
                    load       <= 1'b1;
                    frame_done <= last;
                end
            end
        end
    end
endmodule

// File: tb/tb_window_builder.sv
// tb/tb_window_builder.sv - randomized self-checking bench for window_builder
module tb_window_builder;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [23:0]  pix_in = '0;
    logic         pix_valid = 1'b0;
    logic         sof = 1'b0;
    logic [215:0] w;
    logic         load;
    logic         frame_done;

    window_builder #(.IMG_W(4), .IMG_H(4)) dut (
        .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid),
        .sof(sof), .w(w), .load(load), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: image array of the current frame plus raster position
    logic [23:0]  mimg [4][4];
    int           mrow = 0, mcol = 0;
    logic [215:0] exp_w = '0;
    bit           exp_load, exp_fd;
    logic [215:0] got [$];
    int           fd_at [$];

    localparam logic [215:0] FIRST_W =
        216'h000000_010101_020202_101010_111111_121212_202020_212121_222222;
    localparam logic [215:0] LAST_W =
        216'h111111_121212_131313_212121_222222_232323_313131_323232_333333;

    function automatic logic [23:0] pat(input int r, input int c);
        logic [7:0] v;
        v = 8'(16 * r + c);
        return {v, v, v};
    endfunction

    function automatic logic [215:0] win(input int r, input int c);
        logic [215:0] res = '0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
                res = {res[191:0], mimg[r-2+dr][c-2+dc]};
        return res;
    endfunction

    // k-th window of the test-plan frame: centres (1,1),(1,2),(2,1),(2,2)
    function automatic logic [215:0] golden(input int k);
        logic [215:0] res = '0;
        int cr = 1 + k / 2, cc = 1 + k % 2;
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
                res = {res[191:0], pat(cr + dr, cc + dc)};
        return res;
    endfunction

    task automatic cyc(input bit v, input bit s, input logic [23:0] p);
        pix_valid = v; sof = s; pix_in = p;
        exp_load = 1'b0; exp_fd = 1'b0;
        if (v) begin
            if (s) begin mrow = 0; mcol = 0; end
            mimg[mrow][mcol] = p;
            if (mrow >= 2 && mcol >= 2) begin
                exp_load = 1'b1;
                exp_fd   = (mrow == 3 && mcol == 3);
                exp_w    = win(mrow, mcol);
            end
            mcol++;
            if (mcol == 4) begin mcol = 0; mrow = (mrow + 1) % 4; end
        end
        @(posedge clk); #1;
        checks += 3;
        if (load !== exp_load) begin
            errors++; $display("FAIL load: got %b expected %b at %0t", load, exp_load, $time);
        end
        if (frame_done !== exp_fd) begin
            errors++; $display("FAIL frame_done: got %b expected %b at %0t", frame_done, exp_fd, $time);
        end
        if (w !== exp_w) begin
            errors++; $display("FAIL w: got %h expected %h at %0t", w, exp_w, $time);
        end
        if (load === 1'b1) begin
            got.push_back(w);
            if (frame_done === 1'b1) fd_at.push_back(got.size());
        end
        pix_valid = 1'b0; sof = 1'b0;
    endtask

    task automatic send_frame(input bit with_sof, input int max_gap);
        for (int k = 0; k < 16; k++) begin
            cyc(1'b1, with_sof && k == 0, pat(k / 4, k % 4));
            if (max_gap > 0) repeat ($urandom_range(1, max_gap)) cyc(1'b0, 1'b0, 24'($urandom));
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pix_valid = 1'b0; sof = 1'b0;
        @(posedge clk); #1;
        mrow = 0; mcol = 0; exp_w = '0;
        checks += 3;
        if (load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", load); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        if (w !== '0) begin errors++; $display("FAIL reset_w: got %h expected 0", w); end
        rst_n = 1'b1;
    endtask

    task automatic check_golden(input string tag, input int base);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (base + k >= got.size()) begin
                errors++; $display("FAIL %s_missing: window %0d absent, got %0d windows", tag, k, got.size());
            end else if (got[base + k] !== golden(k)) begin
                errors++; $display("FAIL %s_win%0d: got %h expected %h", tag, k, got[base + k], golden(k));
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        repeat (2) cyc(1'b0, 1'b0, 24'h0);
    endtask

    task automatic test_full_frame();
        got.delete(); fd_at.delete();
        send_frame(1'b1, 0);
        cyc(1'b0, 1'b0, 24'h0);
        checks += 4;
        if (got.size() != 4) begin errors++; $display("FAIL full_count: got %0d expected 4", got.size()); end
        if (got.size() > 0 && got[0] !== FIRST_W) begin
            errors++; $display("FAIL full_first: got %h expected %h", got[0], FIRST_W);
        end
        if (got.size() > 3 && got[3] !== LAST_W) begin
            errors++; $display("FAIL full_last: got %h expected %h", got[3], LAST_W);
        end
        if (fd_at.size() != 1 || fd_at[0] != 4) begin
            errors++; $display("FAIL full_frame_done: got %0d pulses expected 1 on window 4", fd_at.size());
        end
        check_golden("full", 0);
    endtask

    task automatic test_gaps();
        got.delete(); fd_at.delete();
        send_frame(1'b1, 3);
        checks++;
        if (got.size() != 4) begin errors++; $display("FAIL gaps_count: got %0d expected 4", got.size()); end
        check_golden("gaps", 0);
    endtask

    task automatic test_back_to_back();
        got.delete(); fd_at.delete();
        send_frame(1'b1, 0);
        send_frame(1'b1, 0);
        cyc(1'b0, 1'b0, 24'h0);
        checks += 2;
        if (got.size() != 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", got.size()); end
        if (fd_at.size() != 2) begin errors++; $display("FAIL b2b_frame_done: got %0d pulses expected 2", fd_at.size()); end
        check_golden("b2b_f1", 0);
        check_golden("b2b_f2", 4);
    endtask

    task automatic test_sof_resync();
        got.delete(); fd_at.delete();
        for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 24'($urandom));
        checks++;
        if (got.size() != 0) begin errors++; $display("FAIL resync_early: got %0d loads expected 0", got.size()); end
        send_frame(1'b1, 0);
        checks++;
        if (got.size() != 4) begin errors++; $display("FAIL resync_count: got %0d expected 4", got.size()); end
        check_golden("resync", 0);
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 12; k++) cyc(1'b1, k == 0, pat(k / 4, k % 4));
        do_reset();
        got.delete(); fd_at.delete();
        send_frame(1'b0, 0);
        cyc(1'b0, 1'b0, 24'h0);
        checks += 2;
        if (got.size() != 4) begin errors++; $display("FAIL rstmid_count: got %0d expected 4", got.size()); end
        if (fd_at.size() != 1) begin errors++; $display("FAIL rstmid_frame_done: got %0d pulses expected 1", fd_at.size()); end
        check_golden("rstmid", 0);
    endtask

    task automatic test_random();
        got.delete(); fd_at.delete();
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 16; k++) begin
                cyc(1'b1, f == 0 && k == 0, 24'($urandom));
                repeat ($urandom_range(0, 2)) cyc(1'b0, 1'($urandom), 24'($urandom));
            end
        checks++;
        if (got.size() != 12) begin errors++; $display("FAIL random_count: got %0d expected 12", got.size()); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_gaps();
        test_back_to_back();
        test_sof_resync();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
